// File: rtl/burst_read_capture.sv
// Captures Cellular RAM burst-read words (Mode == DPRead, WAIT low) into a first-word-fall-through FIFO.
// Define BURST_WAIT_TIMEOUT_EN to add a WAIT timeout that aborts the burst and pulses TimeoutErr.
module burst_read_capture #(
    parameter int unsigned BURST_LEN = 4,
    parameter int unsigned DEPTH     = 8
`ifdef BURST_WAIT_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT   = 15
`endif
) (
    input  logic                       CLK,
    input  logic                       Reset,
    input  logic [2:0]                 Mode,
    input  logic                       ConWait,
    input  logic [15:0]                MemData,
    output logic [15:0]                DataOut,
    output logic                       DataValid,
    input  logic                       DataReady,
    output logic [$clog2(DEPTH+1)-1:0] Level,
    output logic                       Full,
    output logic                       BurstDone,
    output logic                       Aborted,
    output logic                       Overflow
`ifdef BURST_WAIT_TIMEOUT_EN
    ,
    output logic                       TimeoutErr
`endif
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned LvlW = $clog2(DEPTH + 1);
    localparam int unsigned CntW = $clog2(BURST_LEN + 1);
    localparam logic [2:0]  DPRead = 3'b001;

    typedef enum logic [2:0] {
        Idle    = 3'b001,
        Capture = 3'b010,
        Done    = 3'b100
    } state_t;

    state_t            state, stateNext;
    logic [CntW-1:0]   wordCnt, cntNext;
    logic              isRead, pushReq, pop, wrEn, dropWord;
    logic              doneNext, abortNext;
    logic [PtrW-1:0]   wrPtr, rdPtr;
    logic [15:0]       mem [DEPTH];

`ifdef BURST_WAIT_TIMEOUT_EN
    localparam int unsigned WaitW = $clog2(TIMEOUT + 1);
    logic [WaitW-1:0]  waitCnt, waitNext;
    logic              timeoutNext;
`endif

    assign isRead = (Mode == DPRead);

    always_comb begin
        stateNext = state;
        cntNext   = wordCnt;
        pushReq   = 1'b0;
        doneNext  = 1'b0;
        abortNext = 1'b0;
`ifdef BURST_WAIT_TIMEOUT_EN
        waitNext    = '0;
        timeoutNext = 1'b0;
`endif
        case (state)
            // Idle and Capture share the push path so the first word can land on the entry cycle
            Idle, Capture: begin
                if (!isRead) begin
                    if (state == Capture) begin
                        stateNext = Idle;
                        cntNext   = '0;
                        abortNext = 1'b1;
                    end
                end else begin
                    stateNext = Capture;
                    if (!ConWait) begin
                        pushReq = 1'b1;
                        if (wordCnt == CntW'(BURST_LEN - 1)) begin
                            stateNext = Done;
                            cntNext   = '0;
                            doneNext  = 1'b1;
                        end else begin
                            cntNext = wordCnt + 1'b1;
                        end
                    end
`ifdef BURST_WAIT_TIMEOUT_EN
                    else if (state == Capture) begin
                        if (waitCnt == WaitW'(TIMEOUT - 1)) begin
                            stateNext   = Idle;
                            cntNext     = '0;
                            abortNext   = 1'b1;
                            timeoutNext = 1'b1;
                        end else begin
                            waitNext = waitCnt + 1'b1;
                        end
                    end
`endif
                end
            end
            Done: begin
                if (!isRead) stateNext = Idle;
            end
            default: stateNext = Idle;
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state     <= Idle;
            wordCnt   <= '0;
            BurstDone <= 1'b0;
            Aborted   <= 1'b0;
        end else begin
            state     <= stateNext;
            wordCnt   <= cntNext;
            BurstDone <= doneNext;
            Aborted   <= abortNext;
        end
    end

`ifdef BURST_WAIT_TIMEOUT_EN
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            waitCnt    <= '0;
            TimeoutErr <= 1'b0;
        end else begin
            waitCnt    <= waitNext;
            TimeoutErr <= timeoutNext;
        end
    end
`endif

    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign Full      = (Level == LvlW'(DEPTH));
    assign DataValid = (Level != '0);
    assign DataOut   = DataValid ? mem[rdPtr] : '0;
    assign pop       = DataValid && DataReady;
    assign wrEn      = pushReq && (!Full || pop);
    assign dropWord  = pushReq && Full && !pop;

    always_ff @(posedge CLK) begin
        if (wrEn) mem[wrPtr] <= MemData;
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            Level    <= '0;
            Overflow <= 1'b0;
        end else begin
            if (wrEn) wrPtr <= wrPtr + 1'b1;
            if (pop)  rdPtr <= rdPtr + 1'b1;
            case ({wrEn, pop})
                2'b10:   Level <= Level + 1'b1;
                2'b01:   Level <= Level - 1'b1;
                default: Level <= Level;
            endcase
            if (dropWord) Overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_burst_read_capture.sv
// Self-checking bench for burst_read_capture: directed scenarios plus random traffic against a queue model.
// Covers the BURST_WAIT_TIMEOUT_EN build when that macro is defined.
module tb_burst_read_capture;

    localparam int unsigned BURST_LEN = 4;
    localparam int unsigned DEPTH     = 8;
    localparam int unsigned TIMEOUT   = 15;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic [2:0]  Mode = 3'b000;
    logic        ConWait = 1'b0;
    logic [15:0] MemData = 16'h0000;
    logic        DataReady = 1'b0;
    logic [15:0] DataOut;
    logic        DataValid;
    logic [3:0]  Level;
    logic        Full, BurstDone, Aborted, Overflow;
`ifdef BURST_WAIT_TIMEOUT_EN
    logic        TimeoutErr;
`endif

    burst_read_capture #(.BURST_LEN(BURST_LEN), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .Reset(Reset), .Mode(Mode), .ConWait(ConWait), .MemData(MemData),
        .DataOut(DataOut), .DataValid(DataValid), .DataReady(DataReady), .Level(Level),
        .Full(Full), .BurstDone(BurstDone), .Aborted(Aborted), .Overflow(Overflow)
`ifdef BURST_WAIT_TIMEOUT_EN
        , .TimeoutErr(TimeoutErr)
`endif
    );

    always #5 CLK = ~CLK;

    int unsigned nChecks = 0;
    int unsigned nFails  = 0;

    // Reference model: a word queue plus burst bookkeeping
    logic [15:0] q[$];
    bit          active, locked, expDone, expAbort, expTo, expOvf;
    int unsigned words, waitRun;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic [2:0] m, input logic w, input logic [15:0] d, input logic r);
        bit isRead, doPop, wasFull, push;
        isRead   = (m == 3'b001);
        doPop    = (q.size() != 0) && r;
        wasFull  = (q.size() == DEPTH);
        push     = 1'b0;
        expDone  = 1'b0;
        expAbort = 1'b0;
        expTo    = 1'b0;
        if (locked) begin
            locked  = isRead;
            waitRun = 0;
        end else if (!isRead) begin
            if (active) expAbort = 1'b1;
            active  = 1'b0;
            words   = 0;
            waitRun = 0;
        end else if (!w) begin
            active  = 1'b1;
            push    = 1'b1;
            waitRun = 0;
            words++;
            if (words == BURST_LEN) begin
                expDone = 1'b1;
                locked  = 1'b1;
                active  = 1'b0;
                words   = 0;
            end
        end else begin
            waitRun = active ? waitRun + 1 : 0;
            active  = 1'b1;
`ifdef BURST_WAIT_TIMEOUT_EN
            if (waitRun == TIMEOUT) begin
                expAbort = 1'b1;
                expTo    = 1'b1;
                active   = 1'b0;
                words    = 0;
                waitRun  = 0;
            end
`endif
        end
        if (doPop) void'(q.pop_front());
        if (push) begin
            if (!wasFull || doPop) q.push_back(d);
            else expOvf = 1'b1;
        end
    endtask

    task automatic checkAll();
        chk("Level", 32'(Level), 32'(q.size()));
        chk("DataValid", 32'(DataValid), 32'(q.size() != 0));
        chk("Full", 32'(Full), 32'(q.size() == DEPTH));
        if (q.size() != 0) chk("DataOut", 32'(DataOut), 32'(q[0]));
        chk("BurstDone", 32'(BurstDone), 32'(expDone));
        chk("Aborted", 32'(Aborted), 32'(expAbort));
        chk("Overflow", 32'(Overflow), 32'(expOvf));
`ifdef BURST_WAIT_TIMEOUT_EN
        chk("TimeoutErr", 32'(TimeoutErr), 32'(expTo));
`endif
    endtask

    task automatic step(input logic [2:0] m, input logic w, input logic [15:0] d, input logic r);
        Mode = m; ConWait = w; MemData = d; DataReady = r;
        @(posedge CLK);
        model(m, w, d, r);
        #1;
        checkAll();
    endtask

    task automatic checkZero(input string tag);
        chk({tag, "_Level"}, 32'(Level), 32'd0);
        chk({tag, "_DataValid"}, 32'(DataValid), 32'd0);
        chk({tag, "_DataOut"}, 32'(DataOut), 32'd0);
        chk({tag, "_Full"}, 32'(Full), 32'd0);
        chk({tag, "_BurstDone"}, 32'(BurstDone), 32'd0);
        chk({tag, "_Aborted"}, 32'(Aborted), 32'd0);
        chk({tag, "_Overflow"}, 32'(Overflow), 32'd0);
`ifdef BURST_WAIT_TIMEOUT_EN
        chk({tag, "_TimeoutErr"}, 32'(TimeoutErr), 32'd0);
`endif
    endtask

    task automatic doReset(input string tag);
        Reset = 1'b1; Mode = 3'b000; ConWait = 1'b0; MemData = '0; DataReady = 1'b0;
        #1;
        checkZero(tag);
        q.delete();
        active = 0; locked = 0; words = 0; waitRun = 0;
        expDone = 0; expAbort = 0; expTo = 0; expOvf = 0;
        @(posedge CLK);
        #1;
        Reset = 1'b0;
    endtask

    task automatic burst(input logic [15:0] base, input logic r);
        for (int i = 0; i < 4; i++) step(3'b001, 1'b0, base + 16'(i), r);
        step(3'b000, 1'b0, 16'h0, r);
    endtask

    initial begin
        logic [15:0] stallExp [4];
        logic        stallWait [7];
        int unsigned doneCnt;
        stallExp  = '{16'h1, 16'h4, 16'h5, 16'h7};
        stallWait = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

        @(posedge CLK);
        doReset("reset");

        // Pop on an empty FIFO is ignored
        step(3'b000, 1'b0, 16'h0, 1'b1);

        // Basic burst: six DPRead cycles, only four words captured
        doneCnt = 0;
        for (int i = 0; i < 6; i++) begin
            step(3'b001, 1'b0, 16'hA000 + 16'(i), 1'b0);
            doneCnt += 32'(BurstDone);
        end
        chk("basic_level", 32'(Level), 32'd4);
        chk("basic_head", 32'(DataOut), 32'hA000);
        chk("basic_valid", 32'(DataValid), 32'd1);
        chk("basic_done_pulses", doneCnt, 32'd1);
        for (int i = 0; i < 4; i++) step(3'b000, 1'b0, 16'h0, 1'b1);

        // WAIT stalls
        doneCnt = 0;
        for (int i = 0; i < 7; i++) begin
            step(3'b001, stallWait[i], 16'(i + 1), 1'b0);
            if (i < 6) doneCnt += 32'(BurstDone);
        end
        chk("stall_done_late", doneCnt, 32'd0);
        chk("stall_done", 32'(BurstDone), 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk("stall_order", 32'(DataOut), 32'(stallExp[i]));
            step(3'b000, 1'b0, 16'h0, 1'b1);
        end

        // Abort after two words, then a full burst
        step(3'b001, 1'b0, 16'hB000, 1'b0);
        step(3'b001, 1'b0, 16'hB001, 1'b0);
        step(3'b000, 1'b0, 16'h0, 1'b0);
        chk("abort_pulse", 32'(Aborted), 32'd1);
        chk("abort_level", 32'(Level), 32'd2);
        chk("abort_nodone", 32'(BurstDone), 32'd0);
        burst(16'hB100, 1'b0);
        chk("abort_next_level", 32'(Level), 32'd6);
        for (int i = 0; i < 6; i++) step(3'b000, 1'b0, 16'h0, 1'b1);

        // Overflow: three bursts without pops
        doReset("reset2");
        for (int b = 0; b < 3; b++) burst(16'hC000 + 16'(4 * b), 1'b0);
        chk("ovf_level", 32'(Level), 32'd8);
        chk("ovf_flag", 32'(Overflow), 32'd1);
        chk("ovf_head", 32'(DataOut), 32'hC000);
        for (int i = 0; i < 8; i++) begin
            chk("ovf_drain", 32'(DataOut), 32'hC000 + 32'(i));
            step(3'b000, 1'b0, 16'h0, 1'b1);
        end
        chk("ovf_empty", 32'(Level), 32'd0);

        // Simultaneous push/pop at Full
        doReset("reset3");
        burst(16'hD000, 1'b0);
        burst(16'hD004, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(3'b001, 1'b0, 16'hE000 + 16'(i), 1'b1);
            chk("pp_level", 32'(Level), 32'd8);
        end
        chk("pp_noovf", 32'(Overflow), 32'd0);
        step(3'b000, 1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            chk("pp_order", 32'(DataOut), (i < 4) ? 32'hD004 + 32'(i) : 32'hE000 + 32'(i - 4));
            step(3'b000, 1'b0, 16'h0, 1'b1);
        end

        // Asynchronous reset mid-capture
        step(3'b001, 1'b0, 16'hF000, 1'b0);
        step(3'b001, 1'b0, 16'hF001, 1'b0);
        doReset("midreset");
        step(3'b000, 1'b0, 16'h0, 1'b0);

`ifdef BURST_WAIT_TIMEOUT_EN
        step(3'b001, 1'b0, 16'h7000, 1'b0);
        for (int i = 0; i < TIMEOUT; i++) step(3'b001, 1'b1, 16'h7100, 1'b0);
        chk("to_err", 32'(TimeoutErr), 32'd1);
        chk("to_abort", 32'(Aborted), 32'd1);
        step(3'b000, 1'b0, 16'h0, 1'b0);
        step(3'b001, 1'b0, 16'h7200, 1'b0);
        for (int i = 0; i < TIMEOUT - 1; i++) step(3'b001, 1'b1, 16'h7300, 1'b0);
        step(3'b001, 1'b0, 16'h7400, 1'b0);
        chk("to_none_err", 32'(TimeoutErr), 32'd0);
        chk("to_none_abort", 32'(Aborted), 32'd0);
        step(3'b000, 1'b0, 16'h0, 1'b1);
`endif

        // Random traffic
        doReset("reset4");
        for (int i = 0; i < 600; i++) begin
            logic [2:0] m;
            m = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : 3'b001;
            step(m, ($urandom_range(0, 2) == 0), 16'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
